// File: rtl/fft_pkg.sv
// fft_pkg: widths, complex word type and twiddle constants shared by the 16-point FFT datapath.
package fft_pkg;
  localparam int FFT_N  = 16;
  localparam int DATA_W = 16;
  localparam int WORD_W = 32;
  localparam int IDX_W  = 4;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } fft_word_t;

  // W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16) in Q1.15, k = 0..7
  localparam logic signed [DATA_W-1:0] TW_COS [8] = '{
    16'sd32767, 16'sd30274, 16'sd23170, 16'sd12540,
    16'sd0, -16'sd12540, -16'sd23170, -16'sd30274
  };
  localparam logic signed [DATA_W-1:0] TW_SIN [8] = '{
    16'sd0, 16'sd12540, 16'sd23170, 16'sd30274,
    16'sd32767, 16'sd30274, 16'sd23170, 16'sd12540
  };

  function automatic fft_word_t real_to_word(input logic [DATA_W-1:0] sample);
    fft_word_t w;
    w.re = sample;
    w.im = '0;
    return w;
  endfunction
endpackage

// File: rtl/fft_buf_bank.sv
// fft_buf_bank: one 16-word frame store; each written sample lands at word idx as {sample, 16'h0000}.
module fft_buf_bank
  import fft_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_W-1:0]     sample,
  output fft_word_t [FFT_N-1:0] words
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words <= '0;
    end else if (we) begin
      words[idx] <= real_to_word(sample);
    end
  end
endmodule

// File: rtl/fft_input_buffer.sv
// fft_input_buffer: serial-to-parallel 16-sample frame buffer feeding fft_stage1.
// Define FFT_IN_PINGPONG_EN for two banks; otherwise one bank with a FILL/HOLD handshake.
module fft_input_buffer
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fir_valid,
  input  logic [DATA_W-1:0] fir_d,
  output logic              in_ready,
  output logic              fft_valid,
  input  logic              fft_ready,
  output logic [WORD_W-1:0] buf_data0_out,
  output logic [WORD_W-1:0] buf_data1_out,
  output logic [WORD_W-1:0] buf_data2_out,
  output logic [WORD_W-1:0] buf_data3_out,
  output logic [WORD_W-1:0] buf_data4_out,
  output logic [WORD_W-1:0] buf_data5_out,
  output logic [WORD_W-1:0] buf_data6_out,
  output logic [WORD_W-1:0] buf_data7_out,
  output logic [WORD_W-1:0] buf_data8_out,
  output logic [WORD_W-1:0] buf_data9_out,
  output logic [WORD_W-1:0] buf_data10_out,
  output logic [WORD_W-1:0] buf_data11_out,
  output logic [WORD_W-1:0] buf_data12_out,
  output logic [WORD_W-1:0] buf_data13_out,
  output logic [WORD_W-1:0] buf_data14_out,
  output logic [WORD_W-1:0] buf_data15_out
);
  logic [IDX_W-1:0]      wr_idx;
  logic                  accept;
  logic                  complete;
  logic                  transfer;
  fft_word_t [FFT_N-1:0] rd_words;

  assign accept   = fir_valid && in_ready;
  assign complete = accept && (wr_idx == IDX_W'(FFT_N - 1));
  assign transfer = fft_valid && fft_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
    end else if (accept) begin
      wr_idx <= complete ? '0 : wr_idx + 1'b1;
    end
  end

`ifdef FFT_IN_PINGPONG_EN
  logic                  wr_bank;
  logic                  rd_bank;
  logic [1:0]            full;
  fft_word_t [FFT_N-1:0] bank_words [2];

  assign in_ready  = !full[wr_bank];
  assign fft_valid = full[rd_bank];
  assign rd_words  = bank_words[rd_bank];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_buf_bank u_bank (
      .clk    (clk),
      .rst    (rst),
      .we     (accept && (int'(wr_bank) == b)),
      .idx    (wr_idx),
      .sample (fir_d),
      .words  (bank_words[b])
    );
  end

  // A completion can only target an empty bank and a transfer a full one, so the two never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      if (complete) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= !wr_bank;
      end
      if (transfer) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= !rd_bank;
      end
    end
  end
`else
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]            state;
  fft_word_t [FFT_N-1:0] bank_words;

  assign in_ready  = (state == FILL);
  assign fft_valid = (state == HOLD);
  assign rd_words  = bank_words;

  fft_buf_bank u_bank (
    .clk    (clk),
    .rst    (rst),
    .we     (accept),
    .idx    (wr_idx),
    .sample (fir_d),
    .words  (bank_words)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      case (state)
        FILL:    if (complete) state <= HOLD;
        HOLD:    if (transfer) state <= FILL;
        default: state <= FILL;
      endcase
    end
  end
`endif

  assign buf_data0_out  = rd_words[0];
  assign buf_data1_out  = rd_words[1];
  assign buf_data2_out  = rd_words[2];
  assign buf_data3_out  = rd_words[3];
  assign buf_data4_out  = rd_words[4];
  assign buf_data5_out  = rd_words[5];
  assign buf_data6_out  = rd_words[6];
  assign buf_data7_out  = rd_words[7];
  assign buf_data8_out  = rd_words[8];
  assign buf_data9_out  = rd_words[9];
  assign buf_data10_out = rd_words[10];
  assign buf_data11_out = rd_words[11];
  assign buf_data12_out = rd_words[12];
  assign buf_data13_out = rd_words[13];
  assign buf_data14_out = rd_words[14];
  assign buf_data15_out = rd_words[15];
endmodule

// File: tb/tb_fft_input_buffer.sv
// tb_fft_input_buffer: scoreboard bench for fft_input_buffer; builds in either banking mode.
`timescale 1ns/1ps
module tb_fft_input_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        fir_valid;
  logic [15:0] fir_d;
  logic        in_ready;
  logic        fft_valid;
  logic        fft_ready;
  logic [31:0] buf_data [16];

`ifdef FFT_IN_PINGPONG_EN
  localparam logic [31:0] EXP_READY_AFTER_FRAME = 32'd1;
  localparam int          EXP_PERIOD = 16;
  localparam int          EXP_GAP    = 1;
  localparam int          BP_FILL    = 32;
`else
  localparam logic [31:0] EXP_READY_AFTER_FRAME = 32'd0;
  localparam int          EXP_PERIOD = 17;
  localparam int          EXP_GAP    = 2;
  localparam int          BP_FILL    = 16;
`endif

  fft_input_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .fir_valid      (fir_valid),
    .fir_d          (fir_d),
    .in_ready       (in_ready),
    .fft_valid      (fft_valid),
    .fft_ready      (fft_ready),
    .buf_data0_out  (buf_data[0]),
    .buf_data1_out  (buf_data[1]),
    .buf_data2_out  (buf_data[2]),
    .buf_data3_out  (buf_data[3]),
    .buf_data4_out  (buf_data[4]),
    .buf_data5_out  (buf_data[5]),
    .buf_data6_out  (buf_data[6]),
    .buf_data7_out  (buf_data[7]),
    .buf_data8_out  (buf_data[8]),
    .buf_data9_out  (buf_data[9]),
    .buf_data10_out (buf_data[10]),
    .buf_data11_out (buf_data[11]),
    .buf_data12_out (buf_data[12]),
    .buf_data13_out (buf_data[13]),
    .buf_data14_out (buf_data[14]),
    .buf_data15_out (buf_data[15])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int last_accept = 0;
  int model_idx = 0;
  int pushed_frames = 0;
  int delivered_frames = 0;
  logic [31:0]  model_frame [16];
  logic [511:0] exp_q [$];
  logic [15:0]  neg_vals [16];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  function automatic void modelAccept(input logic [15:0] s);
    logic [511:0] f;
    model_frame[model_idx] = {s, 16'h0000};
    model_idx++;
    if (model_idx == 16) begin
      for (int i = 0; i < 16; i++) f[i*32 +: 32] = model_frame[i];
      exp_q.push_back(f);
      pushed_frames++;
      model_idx = 0;
    end
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the sample.
  task automatic applyStimulus(input logic [15:0] s);
    int waited = 0;
    fir_valid = 1'b1;
    fir_d     = s;
    while (!in_ready) begin
      @(posedge clk); #1;
      waited++;
      if (waited > 200) begin
        checks++;
        failures++;
        $display("[TB] FAIL accept_timeout actual=no_in_ready required=in_ready sample=%h", s);
        fir_valid = 1'b0;
        return;
      end
    end
    modelAccept(s);
    @(posedge clk); #1;
    last_accept = cycle;
    fir_valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Every presented frame is compared against the queue head; a frame is popped when it transfers.
  always @(negedge clk) begin : monitor
    logic [511:0] act;
    if (!rst && fft_valid) begin
      for (int i = 0; i < 16; i++) act[i*32 +: 32] = buf_data[i];
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_frame actual=%h required=none", act);
        if (fft_ready) delivered_frames++;
      end else begin
        if (act !== exp_q[0]) begin
          failures++;
          $display("[TB] FAIL frame%0d actual=%h required=%h", delivered_frames, act, exp_q[0]);
        end
        if (fft_ready) begin
          void'(exp_q.pop_front());
          delivered_frames++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first_a, last_a, first_b, raise_cycle, start_c;
    neg_vals = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFE, 16'h8001, 16'h1234, 16'hABCD,
                 16'h0000, 16'hC000, 16'h4000, 16'hFF00, 16'h00FF, 16'h5555, 16'hAAAA, 16'h7FFE};
    rst = 1'b1;
    fir_valid = 1'b0;
    fir_d = '0;
    fft_ready = 1'b0;

    // Reset state
    @(posedge clk); #1;
    checkOutput("rst_fft_valid", 32'(fft_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 16; i++) checkOutput($sformatf("rst_word%0d", i), buf_data[i], 32'h0);
    rst = 1'b0;
    $display("[TB] reset released");

    // Samples 1..16 with downstream always ready
    fft_ready = 1'b1;
    for (int i = 1; i <= 16; i++) applyStimulus(16'(i));
    checkOutput("t1_fft_valid", 32'(fft_valid), 32'd1);
    checkOutput("t1_in_ready", 32'(in_ready), EXP_READY_AFTER_FRAME);
    checkOutput("t1_word0", buf_data[0], 32'h00010000);
    checkOutput("t1_word15", buf_data[15], 32'h00100000);
    waitCycles(1);
    checkOutput("t1_valid_pulse", 32'(fft_valid), 32'd0);

    // Negative samples, then a back-to-back frame for period and stall measurement
    for (int i = 0; i < 16; i++) begin
      applyStimulus(neg_vals[i]);
      if (i == 0) first_a = last_accept;
      if (i == 15) last_a = last_accept;
    end
    checkOutput("neg_word0", buf_data[0], 32'hFFFF0000);
    checkOutput("neg_word1", buf_data[1], 32'h80000000);
    checkOutput("neg_word2", buf_data[2], 32'h7FFF0000);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(16'h0200 + 16'(i));
      if (i == 0) first_b = last_accept;
    end
    checkOutput("frame_period", 32'(first_b - first_a), 32'(EXP_PERIOD));
    checkOutput("stall_gap", 32'(first_b - last_a), 32'(EXP_GAP));
    waitCycles(3);

    // Backpressure: fill every bank, hold, then release
    $display("[TB] backpressure phase");
    fft_ready = 1'b0;
    for (int i = 0; i < BP_FILL; i++) begin
      applyStimulus(16'h0300 + 16'(i));
      if (i == 15) checkOutput("bp_in_ready_after_first", 32'(in_ready), EXP_READY_AFTER_FRAME);
    end
    checkOutput("bp_in_ready_full", 32'(in_ready), 32'd0);
    repeat (4) begin
      waitCycles(1);
      checkOutput("bp_hold_valid", 32'(fft_valid), 32'd1);
      checkOutput("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    fft_ready = 1'b1;
    raise_cycle = cycle;
    applyStimulus(16'h0300 + 16'(BP_FILL));
    checkOutput("bp_resume_cycle", 32'(last_accept - raise_cycle), 32'd2);
    for (int i = 1; i < 16; i++) applyStimulus(16'h0300 + 16'(BP_FILL + i));
    waitCycles(3);

`ifdef FFT_IN_PINGPONG_EN
    // Transfer and completion on the same edge, ten frames in a row
    $display("[TB] simultaneous completion/transfer phase");
    fft_ready = 1'b0;
    for (int i = 0; i < 16; i++) applyStimulus(16'h0400 + 16'(i));
    start_c = 0;
    for (int f = 1; f <= 10; f++) begin
      for (int i = 0; i < 16; i++) begin
        if (i == 15) fft_ready = 1'b1;
        applyStimulus(16'h0400 + 16'(f * 16 + i));
        if (f == 1 && i == 0) start_c = last_accept;
      end
      fft_ready = 1'b0;
      checkOutput("sim_one_valid", 32'(fft_valid), 32'd1);
      checkOutput("sim_one_in_ready", 32'(in_ready), 32'd1);
    end
    checkOutput("sim_no_stall", 32'(last_accept - start_c), 32'd159);
    fft_ready = 1'b1;
    waitCycles(3);
`else
    start_c = 0;
`endif

    // Reset in the middle of a frame
    $display("[TB] mid-frame reset phase");
    fft_ready = 1'b1;
    for (int i = 0; i < 7; i++) applyStimulus(16'h0500 + 16'(i));
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_fft_valid", 32'(fft_valid), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 16; i++) checkOutput($sformatf("mid_rst_word%0d", i), buf_data[i], 32'h0);
    model_idx = 0;
    exp_q.delete();
    waitCycles(1);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) applyStimulus(16'd100 + 16'(i));
    checkOutput("post_rst_word0", buf_data[0], 32'h00640000);
    checkOutput("post_rst_word15", buf_data[15], 32'h00730000);
    waitCycles(3);

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("frames_delivered", 32'(delivered_frames), 32'(pushed_frames));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
